usb_fifo_sched: RTL

USB_FIFO_SCHED -- requirements
Module: usb_fifo_sched

---
 rtl/usb_fifo_pkg.sv | 23 ++
 rtl/usb_sync2.sv | 23 ++
 rtl/usb_fifo_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fifo_pkg.sv
// Shared definitions for the USB FIFO scheduler: FSM state encoding,
// requester port identifiers and default strobe/timeout timings.
package usb_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_RD_PULSE,
      ST_WR_PULSE,
      ST_RECOVER
   } state_t;

   // Requester identifiers, also used as the round-robin last-grant pointer
   localparam logic PORT_SNES = 1'b0;
   localparam logic PORT_PRG  = 1'b1;

   // Default timings in clk cycles
   localparam int T_RD_CYC_DEF    = 4;
   localparam int T_WR_CYC_DEF    = 3;
   localparam int T_REC_CYC_DEF   = 2;
   localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/usb_sync2.sv
// Two-flop synchronizer for an asynchronous active-low FIFO status line.
// Resets to 1 so the FIFO reads as "not ready" until real samples arrive.
module usb_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture; first stage may go metastable, second resolves it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_fifo_sched.sv
// USB FIFO access scheduler: arbitrates SNES and bootloader-programming
// requests onto a single asynchronous USB FIFO and generates the read/write
// strobes with fixed pulse and recovery widths.
// Optional feature: define USB_FIFO_TIMEOUT_EN to abandon an operation whose
// FIFO never becomes ready within TIMEOUT_CYC cycles (ack with timeout_err).
module usb_fifo_sched
   import usb_fifo_pkg::*;
#(
   parameter int T_RD_CYC    = T_RD_CYC_DEF,
   parameter int T_WR_CYC    = T_WR_CYC_DEF,
   parameter int T_REC_CYC   = T_REC_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       snes_rd_req,
   input  logic       snes_wr_req,
   input  logic [7:0] snes_wdata,
   output logic       snes_ack,
   input  logic       prg_rd_req,
   output logic       prg_ack,
   output logic [7:0] rdata,
   output logic       timeout_err,
   input  logic       usb_rxf_n,
   input  logic       usb_txe_n,
   output logic       usb_rd_n,
   output logic       usb_wr_n,
   input  logic [7:0] usb_din,
   output logic [7:0] usb_dout,
   output logic       usb_doe,
   output logic       busy
);

   if (T_RD_CYC < 1 || T_RD_CYC > 15) begin : g_bad_rd
      $error("T_RD_CYC must be within 1..15");
   end
   if (T_WR_CYC < 1 || T_WR_CYC > 15) begin : g_bad_wr
      $error("T_WR_CYC must be within 1..15");
   end
   if (T_REC_CYC < 1 || T_REC_CYC > 15) begin : g_bad_rec
      $error("T_REC_CYC must be within 1..15");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_tmo
      $error("TIMEOUT_CYC must be within 1..255");
   end

   localparam logic [3:0] RD_LAST  = 4'(T_RD_CYC - 1);
   localparam logic [3:0] WR_LAST  = 4'(T_WR_CYC - 1);
   localparam logic [3:0] REC_LAST = 4'(T_REC_CYC - 1);

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       rxf_s, txe_s;
   logic       last_grant, port_q, op_wr;
   logic       snes_req;
   logic       grant_en, grant_port, grant_wr;
   logic       ack_set, rd_capture, tmo_hit;

   usb_sync2 u_sync_rxf (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (usb_rxf_n),
      .q     (rxf_s)
   );

   usb_sync2 u_sync_txe (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (usb_txe_n),
      .q     (txe_s)
   );

   assign snes_req = snes_rd_req | snes_wr_req;

   // Next-state, phase counter and grant decisions
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt + 4'd1;
      grant_en   = 1'b0;
      grant_port = PORT_SNES;
      grant_wr   = 1'b0;
      ack_set    = 1'b0;
      rd_capture = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nx = '0;
            if (snes_req && prg_rd_req) begin
               grant_en   = 1'b1;
               grant_port = (last_grant == PORT_PRG) ? PORT_SNES : PORT_PRG;
            end else if (snes_req) begin
               grant_en   = 1'b1;
               grant_port = PORT_SNES;
            end else if (prg_rd_req) begin
               grant_en   = 1'b1;
               grant_port = PORT_PRG;
            end
            // A simultaneous SNES read+write serves the write; read stays pending
            grant_wr = (grant_port == PORT_SNES) && snes_wr_req;
            if (grant_en) begin
               state_nx = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            cnt_nx = '0;
            if (!op_wr && !rxf_s) begin
               state_nx = ST_RD_PULSE;
            end else if (op_wr && !txe_s) begin
               state_nx = ST_WR_PULSE;
            end else if (tmo_hit) begin
               state_nx = ST_IDLE;
               ack_set  = 1'b1;
            end
         end
         ST_RD_PULSE: begin
            if (cnt == RD_LAST) begin
               state_nx   = ST_RECOVER;
               cnt_nx     = '0;
               ack_set    = 1'b1;
               rd_capture = 1'b1;
            end
         end
         ST_WR_PULSE: begin
            if (cnt == WR_LAST) begin
               state_nx = ST_RECOVER;
               cnt_nx   = '0;
               ack_set  = 1'b1;
            end
         end
         ST_RECOVER: begin
            if (cnt == REC_LAST) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // State and phase counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Latch the granted port, operation and write byte; advance round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= PORT_PRG;
         port_q     <= PORT_SNES;
         op_wr      <= 1'b0;
         usb_dout   <= 8'h00;
      end else if (grant_en) begin
         last_grant <= grant_port;
         port_q     <= grant_port;
         op_wr      <= grant_wr;
         if (grant_wr) begin
            usb_dout <= snes_wdata;
         end
      end
   end

   // Capture FIFO data on the edge that ends the read strobe; hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= 8'h00;
      end else if (rd_capture) begin
         rdata <= usb_din;
      end
   end

   // Registered strobes, drive enable, acks and busy derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         usb_rd_n <= 1'b1;
         usb_wr_n <= 1'b1;
         usb_doe  <= 1'b0;
         snes_ack <= 1'b0;
         prg_ack  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         usb_rd_n <= (state_nx != ST_RD_PULSE);
         usb_wr_n <= (state_nx != ST_WR_PULSE);
         // Keep driving through the first recovery cycle for data hold
         usb_doe  <= (state_nx == ST_WR_PULSE) ||
                     ((state == ST_WR_PULSE) && (state_nx == ST_RECOVER));
         snes_ack <= ack_set && (port_q == PORT_SNES);
         prg_ack  <= ack_set && (port_q == PORT_PRG);
         busy     <= (state_nx != ST_IDLE);
      end
   end

`ifdef USB_FIFO_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] tmo_cnt;

   assign tmo_hit = (state == ST_WAIT_RDY) && (tmo_cnt == TMO_LAST);

   // Count cycles spent waiting for FIFO ready; flag an abandoned operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt     <= 8'h00;
         timeout_err <= 1'b0;
      end else begin
         tmo_cnt     <= (state == ST_WAIT_RDY) ? tmo_cnt + 8'd1 : 8'h00;
         timeout_err <= ack_set && (state == ST_WAIT_RDY);
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
